// File: rtl/vend_pkg.sv
// Shared types and coin values for the parametrised vending controller.
package vend_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_VEND,
    ST_CHANGE,
    ST_REFUND
  } state_t;

  localparam int HALF_V = 1;
  localparam int ONE_V  = 2;
  localparam int TWO_V  = 4;

endpackage

// File: rtl/vend_payout.sv
// Loadable down-counter that emits a pulse/gap train of half-unit returns.
// A "fire" load emits the first pulse immediately; a plain load waits one cycle.
module vend_payout #(
  parameter int CNT_W = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             i_load,
  input  logic             i_fire,
  input  logic [CNT_W-1:0] i_val,
  input  logic             i_run,
  output logic             o_money,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_money;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_cnt   <= '0;
      r_money <= 1'b0;
    end else if (i_load) begin
      r_money <= i_fire;
      r_cnt   <= i_fire ? i_val - CNT_W'(1) : i_val;
    end else if (i_run) begin
      // A pulse cycle is always followed by a gap cycle.
      if (r_money) begin
        r_money <= 1'b0;
      end else if (r_cnt != '0) begin
        r_money <= 1'b1;
        r_cnt   <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign o_money = r_money;
  assign o_done  = !r_money && (r_cnt == '0);

endmodule

// File: rtl/vend_fsm_param.sv
// Parametrised vending controller: credit, vend, change, refund, busy reject.
// Optional build macro COIN_TWO_EN adds the two-unit coin input pi_money_two.
module vend_fsm_param
  import vend_pkg::*;
#(
  parameter int PRICE    = 5,
  parameter int CREDIT_W = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic                pi_money_half,
  input  logic                pi_money_one,
`ifdef COIN_TWO_EN
  input  logic                pi_money_two,
`endif
  input  logic                pi_cancel,
  output logic                po_cola,
  output logic                po_money,
  output logic                po_reject,
  output logic                po_busy,
  output logic [CREDIT_W-1:0] po_credit
);

  if (PRICE < 1 || PRICE + 6 >= 2**CREDIT_W) begin : g_bad_params
    $error("vend_fsm_param: PRICE out of range for CREDIT_W");
  end

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  state_t              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic [CREDIT_W-1:0] w_coin_v, w_total, w_load_val;
  logic                w_coin_any, w_busy_now;
  logic                w_load, w_fire;
  logic                w_pay_money, w_pay_done;
  logic                w_cola_nxt, w_reject_nxt, w_busy_nxt;
  logic                r_cola, r_reject, r_busy;

  always_comb begin
    w_coin_v = '0;
    if (pi_money_half) w_coin_v = w_coin_v + CREDIT_W'(HALF_V);
    if (pi_money_one)  w_coin_v = w_coin_v + CREDIT_W'(ONE_V);
`ifdef COIN_TWO_EN
    if (pi_money_two)  w_coin_v = w_coin_v + CREDIT_W'(TWO_V);
`endif
  end

  assign w_coin_any = (w_coin_v != '0);
  assign w_total    = r_credit + w_coin_v;
  assign w_busy_now = (r_state == ST_VEND) || (r_state == ST_CHANGE) ||
                      (r_state == ST_REFUND);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state  <= ST_IDLE;
      r_credit <= '0;
      r_cola   <= 1'b0;
      r_reject <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_credit_nxt;
      r_cola   <= w_cola_nxt;
      r_reject <= w_reject_nxt;
      r_busy   <= w_busy_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_load       = 1'b0;
    w_fire       = 1'b0;
    w_load_val   = '0;
    case (r_state)
      ST_IDLE, ST_COLLECT: begin
        // Cancel wins over vend when both become possible in the same cycle.
        if (pi_cancel && (w_total != '0)) begin
          w_state_nxt  = ST_REFUND;
          w_credit_nxt = '0;
          w_load       = 1'b1;
          w_fire       = 1'b1;
          w_load_val   = w_total;
        end else if (w_total >= PRICE_C) begin
          w_state_nxt  = ST_VEND;
          w_credit_nxt = '0;
          w_load       = 1'b1;
          w_load_val   = w_total - PRICE_C;
        end else if (w_total != '0) begin
          w_state_nxt  = ST_COLLECT;
          w_credit_nxt = w_total;
        end
      end
      ST_VEND:              w_state_nxt = w_pay_done ? ST_IDLE : ST_CHANGE;
      ST_CHANGE, ST_REFUND: if (w_pay_done) w_state_nxt = ST_IDLE;
      default:              w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cola_nxt   = (w_state_nxt == ST_VEND);
    w_busy_nxt   = (w_state_nxt == ST_VEND) || (w_state_nxt == ST_CHANGE) ||
                   (w_state_nxt == ST_REFUND);
    w_reject_nxt = w_busy_now && w_coin_any;
  end

  // VEND acts as the leading gap, so CHANGE starts with a pulse.
  vend_payout #(
    .CNT_W (CREDIT_W)
  ) u_payout (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .i_load  (w_load),
    .i_fire  (w_fire),
    .i_val   (w_load_val),
    .i_run   (w_busy_now),
    .o_money (w_pay_money),
    .o_done  (w_pay_done)
  );

  assign po_cola   = r_cola;
  assign po_money  = w_pay_money;
  assign po_reject = r_reject;
  assign po_busy   = r_busy;
  assign po_credit = r_credit;

endmodule

// File: tb/tb_vend_fsm_param.sv
// Directed self-checking bench for vend_fsm_param (PRICE=5, CREDIT_W=4).
module tb_vend_fsm_param;

  localparam int CREDIT_W = 4;

  logic                sys_clk;
  logic                sys_rst;
  logic                pi_money_half;
  logic                pi_money_one;
`ifdef COIN_TWO_EN
  logic                pi_money_two;
`endif
  logic                pi_cancel;
  logic                po_cola;
  logic                po_money;
  logic                po_reject;
  logic                po_busy;
  logic [CREDIT_W-1:0] po_credit;

  int n_checks = 0;
  int n_errors = 0;

  vend_fsm_param #(
    .PRICE    (5),
    .CREDIT_W (CREDIT_W)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .pi_money_half (pi_money_half),
    .pi_money_one  (pi_money_one),
`ifdef COIN_TWO_EN
    .pi_money_two  (pi_money_two),
`endif
    .pi_cancel     (pi_cancel),
    .po_cola       (po_cola),
    .po_money      (po_money),
    .po_reject     (po_reject),
    .po_busy       (po_busy),
    .po_credit     (po_credit)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Hold the inputs for one cycle, then observe the outputs 1 time unit after the edge.
  task automatic step(input logic h, input logic o, input logic c);
    pi_money_half = h;
    pi_money_one  = o;
    pi_cancel     = c;
    @(posedge sys_clk);
    #1;
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    pi_cancel     = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic cola, input logic money,
                            input logic rej, input logic busy, input int credit);
    check({tag, "_cola"},   po_cola,   cola);
    check({tag, "_money"},  po_money,  money);
    check({tag, "_reject"}, po_reject, rej);
    check({tag, "_busy"},   po_busy,   busy);
    check({tag, "_credit"}, po_credit, credit);
  endtask

  initial begin
    int pulses;
    int cyc;
    sys_rst       = 1'b1;
    pi_money_half = 1'b0;
    pi_money_one  = 1'b0;
    pi_cancel     = 1'b0;
`ifdef COIN_TWO_EN
    pi_money_two  = 1'b0;
`endif
    step(0, 0, 0);
    step(0, 0, 0);
    expect_out("reset", 0, 0, 0, 0, 0);
    sys_rst = 1'b0;
    step(0, 0, 0);
    expect_out("idle", 0, 0, 0, 0, 0);

    // Five half-unit coins: exact price, no change.
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0);
      check("half_credit", po_credit, i);
    end
    step(1, 0, 0);
    expect_out("half_vend", 1, 0, 0, 1, 0);
    step(0, 0, 0);
    expect_out("half_after", 0, 0, 0, 0, 0);
    step(0, 0, 0);
    expect_out("half_idle", 0, 0, 0, 0, 0);

    // Three one-unit coins: 6, one change pulse.
    step(0, 1, 0);
    check("one_credit1", po_credit, 2);
    step(0, 1, 0);
    check("one_credit2", po_credit, 4);
    step(0, 1, 0);
    expect_out("one_vend", 1, 0, 0, 1, 0);
    step(0, 0, 0);
    expect_out("one_pulse", 0, 1, 0, 1, 0);
    step(0, 0, 0);
    expect_out("one_gap", 0, 0, 0, 1, 0);
    step(0, 0, 0);
    expect_out("one_idle", 0, 0, 0, 0, 0);

    // Half+one together twice: 3 then 6.
    step(1, 1, 0);
    check("both_credit", po_credit, 3);
    step(1, 1, 0);
    expect_out("both_vend", 1, 0, 0, 1, 0);
    step(0, 0, 0);
    expect_out("both_pulse", 0, 1, 0, 1, 0);
    step(0, 0, 0);
    expect_out("both_gap", 0, 0, 0, 1, 0);
    step(0, 0, 0);
    expect_out("both_idle", 0, 0, 0, 0, 0);

    // Cancel with nothing inserted is ignored.
    step(0, 0, 1);
    expect_out("cancel_empty", 0, 0, 0, 0, 0);

    // One-unit coin then cancel: two refund pulses with a gap between.
    step(0, 1, 0);
    check("ref_credit", po_credit, 2);
    step(0, 0, 1);
    expect_out("ref_p1", 0, 1, 0, 1, 0);
    step(0, 0, 0);
    expect_out("ref_g1", 0, 0, 0, 1, 0);
    step(0, 0, 0);
    expect_out("ref_p2", 0, 1, 0, 1, 0);
    step(0, 0, 0);
    expect_out("ref_g2", 0, 0, 0, 1, 0);
    step(0, 0, 0);
    expect_out("ref_idle", 0, 0, 0, 0, 0);

    // Coin during CHANGE is rejected and not credited.
    step(0, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    check("rej_vend", po_cola, 1);
    step(0, 0, 0);
    check("rej_pulse", po_money, 1);
    step(1, 0, 0);
    expect_out("rej_flag", 0, 0, 1, 1, 0);
    step(0, 0, 0);
    expect_out("rej_idle", 0, 0, 0, 0, 0);
    step(0, 0, 0);
    expect_out("rej_idle2", 0, 0, 0, 0, 0);

    // Cancel beats vend: credit 4 + half with cancel refunds all 5.
    step(0, 1, 0);
    step(0, 1, 0);
    step(1, 0, 1);
    check("prio_cola", po_cola, 0);
    pulses = po_money ? 1 : 0;
    cyc = 0;
    while (po_busy && cyc < 30) begin
      step(0, 0, 0);
      if (po_money) pulses++;
      check("prio_nocola", po_cola, 0);
      cyc++;
    end
    check("prio_pulses", pulses, 5);
    check("prio_idle", po_busy, 0);

    // Reset between refund pulses abandons the payout.
    step(0, 1, 0);
    step(1, 0, 0);
    check("rst_credit", po_credit, 3);
    step(0, 0, 1);
    check("rst_p1", po_money, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    check("rst_p2", po_money, 1);
    step(0, 0, 0);
    check("rst_g2", po_money, 0);
    sys_rst = 1'b1;
    step(0, 0, 0);
    sys_rst = 1'b0;
    expect_out("rst_mid", 0, 0, 0, 0, 0);
    step(0, 0, 0);
    expect_out("rst_after1", 0, 0, 0, 0, 0);
    step(0, 0, 0);
    expect_out("rst_after2", 0, 0, 0, 0, 0);
    step(1, 0, 0);
    check("rst_newcoin", po_credit, 1);
    step(0, 0, 1);
    check("rst_refund", po_money, 1);
    step(0, 0, 0);
    step(0, 0, 0);
    expect_out("rst_refund_done", 0, 0, 0, 0, 0);

`ifdef COIN_TWO_EN
    // Two-unit plus one-unit coin: 6, vend plus one change pulse.
    pi_money_two = 1'b1;
    step(0, 1, 0);
    pi_money_two = 1'b0;
    expect_out("two_vend", 1, 0, 0, 1, 0);
    step(0, 0, 0);
    expect_out("two_pulse", 0, 1, 0, 1, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    expect_out("two_idle", 0, 0, 0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
